// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - state, opcode and opcode-class definitions for multicycle_ctrl
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_UPPER   = 3'd5,
        CLS_CUSTOM  = 3'd6,
        CLS_ILLEGAL = 3'd7
    } op_class_t;

    localparam logic [6:0] OP_ALU_R   = 7'b0110011;
    localparam logic [6:0] OP_ALU_I   = 7'b0010011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;

endpackage

// File: rtl/mc_opclass_decode.sv
// rtl/mc_opclass_decode.sv - combinational opcode to instruction-class map
module mc_opclass_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] op_class
);

    op_class_t cls;

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_ALU_R, OP_ALU_I: cls = CLS_ALU;
            OP_LOAD:            cls = CLS_LOAD;
            OP_STORE:           cls = CLS_STORE;
            OP_BRANCH:          cls = CLS_BRANCH;
            OP_JAL, OP_JALR:    cls = CLS_JUMP;
            OP_LUI, OP_AUIPC:   cls = CLS_UPPER;
            OP_CUSTOM0:         cls = CLS_CUSTOM;
            default:            cls = CLS_ILLEGAL;
        endcase
    end

    assign op_class = cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM; MULTICYCLE_CTRL_PERF_CNT_EN adds perf counters
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel_data,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        reg_write,
    output logic        instr_retired,
    output logic        halted,
    output logic        bus_err,
    output logic [2:0]  state_dbg,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       started;
    logic       bus_err_q;
    logic       at_limit;
    logic [2:0] op_class_raw;
    op_class_t  op_class;

    mc_opclass_decode u_opclass_decode (
        .opcode   (opcode),
        .op_class (op_class_raw)
    );

    assign op_class = op_class_t'(op_class_raw);
    assign at_limit = (wait_cnt == WAIT_LAST);

    // started holds the first fetch request off until one edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            started   <= 1'b0;
            wait_cnt  <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            state   <= next_state;
            started <= 1'b1;
            if (next_state != state) begin
                wait_cnt <= 8'd0;
            end else if (mem_req) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (next_state == ST_HALT && (state == ST_FETCH || state == ST_MEM)) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        reg_write    = 1'b0;
        halted       = 1'b0;
        case (state)
            ST_FETCH: begin
                if (started) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        next_state = ST_DECODE;
                    end else if (at_limit) begin
                        next_state = ST_HALT;
                    end
                end
            end
            ST_DECODE: begin
                next_state = (op_class == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                case (op_class)
                    CLS_BRANCH: begin
                        pc_write   = 1'b1;
                        pc_sel     = branch_taken;
                        next_state = ST_FETCH;
                    end
                    CLS_JUMP: begin
                        pc_write   = 1'b1;
                        pc_sel     = 1'b1;
                        next_state = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: next_state = ST_MEM;
                    default:             next_state = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                mem_we       = (op_class == CLS_STORE);
                if (mem_ready) begin
                    if (op_class == CLS_STORE) begin
                        pc_write   = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        next_state = ST_WB;
                    end
                end else if (at_limit) begin
                    next_state = ST_HALT;
                end
            end
            ST_WB: begin
                // jumps already moved the PC in EXEC
                reg_write  = 1'b1;
                pc_write   = (op_class != CLS_JUMP);
                next_state = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = ST_HALT;
            end
        endcase
    end

    assign instr_retired = pc_write;
    assign bus_err       = bus_err_q;
    assign state_dbg     = state;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            if (state != ST_HALT) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (instr_retired) begin
                instr_q <= instr_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule
